// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA timing generator and its consumers.
// The generator drives everything except the run enable.
`timescale 1ns/1ps
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  logic          en;
  logic          pix_en;
  logic          hSync;
  logic          vSync;
  logic          bright;
  logic [CW-1:0] hCount;
  logic [CW-1:0] vCount;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  en,
    output pix_en, hSync, vSync, bright, hCount, vCount, line_start, frame_start
  );

  modport slave (
    output en,
    input  pix_en, hSync, vSync, bright, hCount, vCount, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator running on the board clock with a pixel-rate
// enable; counters, syncs, bright and strobes all change together on each pixel step.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int DIV          = 4,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int H_POL        = 0,
  parameter int V_POL        = 0,
  parameter int ACTIVE_FIRST = 1,
  parameter int CW           = 10
)(
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  if (DIV < 1) begin : g_bad_div
    $fatal(1, "vga_timing_gen: DIV must be at least 1");
  end
  if (((64'd1 << CW) < 64'(H_TOTAL)) || ((64'd1 << CW) < 64'(V_TOTAL))) begin : g_bad_cw
    $fatal(1, "vga_timing_gen: CW too small for the line or frame total");
  end
  if ((H_ACTIVE < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
      (V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1)) begin : g_bad_zero
    $fatal(1, "vga_timing_gen: active, porch and sync widths must be non-zero");
  end

  // Returns {hSync, vSync, bright} for a count pair, polarity already applied.
  function automatic logic [2:0] decode(input logic [CW-1:0] h, input logic [CW-1:0] v);
    int   hi;
    int   vi;
    logic hv;
    logic vv;
    logic hs;
    logic vs;
    hi = int'(h);
    vi = int'(v);
    if (ACTIVE_FIRST != 0) begin
      hv = (hi < H_ACTIVE);
      vv = (vi < V_ACTIVE);
      hs = (hi >= H_ACTIVE + H_FP) && (hi < H_ACTIVE + H_FP + H_SYNC);
      vs = (vi >= V_ACTIVE + V_FP) && (vi < V_ACTIVE + V_FP + V_SYNC);
    end else begin
      hs = (hi < H_SYNC);
      vs = (vi < V_SYNC);
      hv = (hi >= H_SYNC + H_BP) && (hi < H_SYNC + H_BP + H_ACTIVE);
      vv = (vi >= V_SYNC + V_BP) && (vi < V_SYNC + V_BP + V_ACTIVE);
    end
    decode = {(hs ? (H_POL != 0) : (H_POL == 0)),
              (vs ? (V_POL != 0) : (V_POL == 0)),
              (hv && vv)};
  endfunction

  logic [DW-1:0] r_div;
  logic [CW-1:0] r_h;
  logic [CW-1:0] r_v;
  logic          r_pix_en;
  logic          r_hs;
  logic          r_vs;
  logic          r_br;
  logic          r_line;
  logic          r_frame;

  logic          w_tick;
  logic [DW-1:0] w_div_nxt;
  logic [CW-1:0] w_h_nxt;
  logic [CW-1:0] w_v_nxt;
  logic [2:0]    w_dec;

  always_comb begin
    w_tick    = bus.en && (r_div == DIV_LAST);
    w_div_nxt = r_div;
    w_h_nxt   = r_h;
    w_v_nxt   = r_v;
    if (bus.en) begin
      w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    end
    if (w_tick) begin
      if (r_h == H_LAST) begin
        w_h_nxt = '0;
        w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        w_h_nxt = r_h + 1'b1;
      end
    end
    // Decoding the next counts keeps the level outputs aligned with the counters.
    w_dec = decode(w_h_nxt, w_v_nxt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div               <= '0;
      r_h                 <= '0;
      r_v                 <= '0;
      r_pix_en            <= 1'b0;
      r_line              <= 1'b0;
      r_frame             <= 1'b0;
      {r_hs, r_vs, r_br}  <= decode(CW'(0), CW'(0));
    end else begin
      r_div               <= w_div_nxt;
      r_h                 <= w_h_nxt;
      r_v                 <= w_v_nxt;
      r_pix_en            <= w_tick;
      r_line              <= w_tick && (w_h_nxt == '0);
      r_frame             <= w_tick && (w_h_nxt == '0) && (w_v_nxt == '0);
      {r_hs, r_vs, r_br}  <= w_dec;
    end
  end

  assign bus.pix_en      = r_pix_en;
  assign bus.hSync       = r_hs;
  assign bus.vSync       = r_vs;
  assign bus.bright      = r_br;
  assign bus.hCount      = r_h;
  assign bus.vCount      = r_v;
  assign bus.line_start  = r_line;
  assign bus.frame_start = r_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing at DIV=4, legacy
// sync-first ordering at DIV=1, and a tiny 7x5 raster with positive hSync.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(10)) b_def ();
  vga_timing_gen_if #(.CW(10)) b_af0 ();
  vga_timing_gen_if #(.CW(10)) b_tiny ();

  assign b_def.en  = en;
  assign b_af0.en  = en;
  assign b_tiny.en = en;

  vga_timing_gen u_def (.clk(clk), .reset(reset), .bus(b_def.master));

  vga_timing_gen #(.DIV(1), .ACTIVE_FIRST(0), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(3))
    u_af0 (.clk(clk), .reset(reset), .bus(b_af0.master));

  vga_timing_gen #(.DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                   .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1))
    u_tiny (.clk(clk), .reset(reset), .bus(b_tiny.master));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    step(2);
    reset = 1'b0;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b1;
    step(3);
    checks++;
    if ({b_def.hCount, b_def.vCount} !== 20'd0) begin
      errors++; $display("FAIL reset_counts: got h=%0d v=%0d expected 0 0", b_def.hCount, b_def.vCount);
    end
    checks++;
    if ({b_def.pix_en, b_def.line_start, b_def.frame_start, b_def.hSync, b_def.vSync, b_def.bright} !== 6'b000111) begin
      errors++; $display("FAIL reset_def_flags: got %b expected 000111",
        {b_def.pix_en, b_def.line_start, b_def.frame_start, b_def.hSync, b_def.vSync, b_def.bright});
    end
    checks++;
    if ({b_af0.hSync, b_af0.vSync, b_af0.bright} !== 3'b000) begin
      errors++; $display("FAIL reset_af0_flags: got %b expected 000", {b_af0.hSync, b_af0.vSync, b_af0.bright});
    end
    checks++;
    if ({b_tiny.hSync, b_tiny.vSync, b_tiny.bright} !== 3'b011) begin
      errors++; $display("FAIL reset_tiny_flags: got %b expected 011", {b_tiny.hSync, b_tiny.vSync, b_tiny.bright});
    end
  endtask

  task automatic test_pix_period();
    int n;
    do_reset();
    n = 0;
    while (b_def.pix_en !== 1'b1 && n < 20) begin step(1); n++; end
    checks++;
    if (n != 4 || b_def.hCount !== 10'd1) begin
      errors++; $display("FAIL first_pix_en: got %0d clks h=%0d expected 4 clks h=1", n, b_def.hCount);
    end
    step(1);
    n = 1;
    while (b_def.pix_en !== 1'b1 && n < 20) begin step(1); n++; end
    checks++;
    if (n != 4 || b_def.hCount !== 10'd2) begin
      errors++; $display("FAIL pix_en_period: got %0d clks h=%0d expected 4 clks h=2", n, b_def.hCount);
    end
  endtask

  task automatic test_line();
    int n, low, hs_fall, hs_rise, br_fall, bad_h;
    logic prev_hs, prev_br;
    do_reset();
    n = 0;
    while (b_def.line_start !== 1'b1 && n < 4000) begin step(1); n++; end
    checks++;
    if (n != 3200 || b_def.hCount !== 10'd0 || b_def.vCount !== 10'd1) begin
      errors++; $display("FAIL first_line_start: got %0d clks v=%0d expected 3200 clks v=1", n, b_def.vCount);
    end
    prev_hs = b_def.hSync; prev_br = b_def.bright;
    low = 0; hs_fall = -1; hs_rise = -1; br_fall = -1; bad_h = -1;
    for (int i = 0; i < 3200; i++) begin
      step(1);
      if (b_def.pix_en === 1'b1) begin
        if (b_def.hSync === 1'b0) low++;
        if (prev_hs === 1'b1 && b_def.hSync === 1'b0) hs_fall = int'(b_def.hCount);
        if (prev_hs === 1'b0 && b_def.hSync === 1'b1) hs_rise = int'(b_def.hCount);
        if (prev_br === 1'b1 && b_def.bright === 1'b0) br_fall = int'(b_def.hCount);
        if (b_def.hSync !== !(b_def.hCount >= 10'd656 && b_def.hCount < 10'd752) && bad_h < 0)
          bad_h = int'(b_def.hCount);
        prev_hs = b_def.hSync; prev_br = b_def.bright;
      end
    end
    checks++;
    if (hs_fall != 656 || hs_rise != 752) begin
      errors++; $display("FAIL hsync_edges: got fall=%0d rise=%0d expected 656 752", hs_fall, hs_rise);
    end
    checks++;
    if (low != 96) begin
      errors++; $display("FAIL hsync_width: got %0d pixels expected 96", low);
    end
    checks++;
    if (br_fall != 640) begin
      errors++; $display("FAIL bright_fall: got h=%0d expected 640", br_fall);
    end
    checks++;
    if (bad_h >= 0) begin
      errors++; $display("FAIL hsync_align: got wrong hSync at h=%0d expected none", bad_h);
    end
    checks++;
    if (b_def.line_start !== 1'b1 || b_def.vCount !== 10'd2) begin
      errors++; $display("FAIL line_period: got ls=%b v=%0d expected 1 2", b_def.line_start, b_def.vCount);
    end
  endtask

  task automatic test_enable_stall();
    int n, seen;
    n = 0;
    while (!(b_def.pix_en === 1'b1 && b_def.hCount == 10'd300) && n < 4000) begin step(1); n++; end
    checks++;
    if (n >= 4000) begin
      errors++; $display("FAIL stall_reach_300: got timeout expected h=300");
    end
    en = 1'b0;
    seen = 0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (b_def.pix_en !== 1'b0 || b_def.line_start !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL stall_pix_en: got %0d strobe cycles expected 0", seen);
    end
    checks++;
    if (b_def.hCount !== 10'd300 || b_def.vCount !== 10'd2 || b_def.hSync !== 1'b1 || b_def.bright !== 1'b1) begin
      errors++; $display("FAIL stall_hold: got h=%0d v=%0d hs=%b br=%b expected 300 2 1 1",
        b_def.hCount, b_def.vCount, b_def.hSync, b_def.bright);
    end
    en = 1'b1;
    n = 0;
    while (b_def.pix_en !== 1'b1 && n < 20) begin step(1); n++; end
    checks++;
    if (n != 4 || b_def.hCount !== 10'd301) begin
      errors++; $display("FAIL stall_resume: got %0d clks h=%0d expected 4 clks h=301", n, b_def.hCount);
    end
  endtask

  task automatic test_active_first0();
    int bright_n, hlow_n, vlow_n, bad;
    do_reset();
    bright_n = 0; hlow_n = 0; vlow_n = 0; bad = 0;
    for (int i = 0; i < 8000; i++) begin
      step(1);
      if (b_af0.bright === 1'b1) bright_n++;
      if (b_af0.hSync === 1'b0) hlow_n++;
      if (b_af0.vSync === 1'b0) vlow_n++;
      if (b_af0.hSync !== !(b_af0.hCount < 10'd96)) bad++;
      if (b_af0.vSync !== !(b_af0.vCount < 10'd2)) bad++;
      if (b_af0.bright !== (b_af0.hCount >= 10'd144 && b_af0.hCount < 10'd784 &&
                            b_af0.vCount >= 10'd5 && b_af0.vCount < 10'd9)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL af0_decode: got %0d misdecoded samples expected 0", bad);
    end
    checks++;
    if (bright_n != 2560) begin
      errors++; $display("FAIL af0_bright_count: got %0d expected 2560", bright_n);
    end
    checks++;
    if (hlow_n != 960 || vlow_n != 1600) begin
      errors++; $display("FAIL af0_sync_count: got h=%0d v=%0d expected 960 1600", hlow_n, vlow_n);
    end
    checks++;
    if (b_af0.frame_start !== 1'b1 || b_af0.hCount !== 10'd0 || b_af0.vCount !== 10'd0) begin
      errors++; $display("FAIL af0_frame_wrap: got fs=%b h=%0d v=%0d expected 1 0 0",
        b_af0.frame_start, b_af0.hCount, b_af0.vCount);
    end
  endtask

  task automatic test_tiny();
    int eh, ev;
    do_reset();
    for (int i = 1; i <= 35; i++) begin
      step(1);
      eh = i % 7;
      ev = (i / 7) % 5;
      checks++;
      if (b_tiny.hCount !== 10'(eh) || b_tiny.vCount !== 10'(ev) || b_tiny.pix_en !== 1'b1) begin
        errors++; $display("FAIL tiny_count: got h=%0d v=%0d pe=%b expected %0d %0d 1",
          b_tiny.hCount, b_tiny.vCount, b_tiny.pix_en, eh, ev);
      end
      checks++;
      if (b_tiny.hSync !== (eh == 5) || b_tiny.vSync !== (ev != 3) || b_tiny.bright !== (eh < 4 && ev < 2)) begin
        errors++; $display("FAIL tiny_levels: got hs=%b vs=%b br=%b at h=%0d v=%0d",
          b_tiny.hSync, b_tiny.vSync, b_tiny.bright, eh, ev);
      end
      checks++;
      if (b_tiny.line_start !== (eh == 0) || b_tiny.frame_start !== (i == 35)) begin
        errors++; $display("FAIL tiny_strobes: got ls=%b fs=%b at step %0d expected %b %b",
          b_tiny.line_start, b_tiny.frame_start, i, (eh == 0), (i == 35));
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    step(1);
    n = 1;
    while (b_tiny.frame_start !== 1'b1 && n < 100) begin step(1); n++; end
    checks++;
    if (n != 35) begin
      errors++; $display("FAIL frame_spacing: got %0d clks expected 35", n);
    end
  endtask

  task automatic test_reset_mid();
    int n, early;
    n = 0;
    while (b_tiny.vCount !== 10'd2 && n < 50) begin step(1); n++; end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (b_tiny.hCount !== 10'd0 || b_tiny.vCount !== 10'd0 || b_tiny.pix_en !== 1'b0) begin
      errors++; $display("FAIL async_reset: got h=%0d v=%0d pe=%b expected 0 0 0",
        b_tiny.hCount, b_tiny.vCount, b_tiny.pix_en);
    end
    step(2);
    reset = 1'b0;
    n = 0;
    early = 0;
    while (b_tiny.frame_start !== 1'b1 && n < 100) begin
      step(1); n++;
    end
    checks++;
    if (n != 35) begin
      errors++; $display("FAIL reset_first_frame: got %0d clks expected 35", n);
    end
  endtask

  initial begin
    test_reset();
    test_pix_period();
    test_line();
    test_enable_stall();
    test_active_first0();
    test_tiny();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
